// File: rtl/sample_fifo_sync.sv
// Single-clock sample FIFO with registered read data, level-derived flags
// and sticky overflow/underflow error flags.
module sample_fifo_sync #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          write_data,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          read_value,
   output logic                       read_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clear_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              rd_acc;
   logic              wr_acc;

   // A full FIFO still takes a write when a read frees a slot in the same
   // cycle; an empty FIFO never forwards write data straight to the output.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= AF_L);
   assign almost_empty = (level <= AE_L);

   // Storage is left uninitialised on reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc && !reset)
         mem[wr_ptr] <= write_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         read_value <= '0;
         read_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         read_valid <= rd_acc;
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            read_value <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         // A fresh error in the clearing cycle wins over clear_err.
         overflow  <= (wr_en & ~wr_acc) | (overflow  & ~clear_err);
         underflow <= (rd_en & ~rd_acc) | (underflow & ~clear_err);
      end
   end

endmodule

// File: tb/tb_sample_fifo_sync.sv
// Directed test of sample_fifo_sync: fill/drain, errors, full/empty
// simultaneous access, wrap streaming and mid-operation reset.
module tb_sample_fifo_sync;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [DATA_W-1:0] write_data;
   logic              rd_en;
   logic [DATA_W-1:0] read_value;
   logic              read_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [4:0]        level;
   logic              overflow;
   logic              underflow;
   logic              clear_err;

   int checks = 0;
   int errors = 0;

   sample_fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .write_data   (write_data),
      .rd_en        (rd_en),
      .read_value   (read_value),
      .read_valid   (read_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after an edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0; write_data = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_rv", read_valid, 0);
      chk("rst_rdata", read_value, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);

      // fill 0x0001..0x0010
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; write_data = 16'(i);
         step();
         chk("fill_level", level, i);
         chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
         chk("fill_full", full, (i == 16) ? 1 : 0);
         chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      end
      write_data = 16'hBEEF;
      step();
      chk("ovf_set", overflow, 1);
      chk("ovf_level", level, 16);
      wr_en = 1'b0;

      for (int i = 1; i <= 16; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_rv", read_valid, 1);
         chk("drain_data", read_value, i);
         chk("drain_level", level, 16 - i);
      end
      rd_en = 1'b0;
      step();
      chk("idle_rv", read_valid, 0);
      chk("hold_data", read_value, 16'h0010);
      chk("drain_empty", empty, 1);
      chk("ovf_sticky", overflow, 1);

      // underflow and clear
      rd_en = 1'b1;
      step();
      chk("unf_set", underflow, 1);
      chk("unf_rv", read_valid, 0);
      chk("unf_hold", read_value, 16'h0010);
      rd_en = 1'b0; clear_err = 1'b1;
      step();
      chk("unf_clr", underflow, 0);
      chk("ovf_clr", overflow, 0);
      rd_en = 1'b1;
      step();
      chk("clr_vs_err", underflow, 1);
      rd_en = 1'b0;
      step();
      chk("clr_again", underflow, 0);
      clear_err = 1'b0;

      // write+read on empty: write only, no fall-through
      wr_en = 1'b1; rd_en = 1'b1; write_data = 16'h0055;
      step();
      chk("we_level", level, 1);
      chk("we_rv", read_valid, 0);
      chk("we_unf", underflow, 1);
      wr_en = 1'b0; clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      chk("we_data", read_value, 16'h0055);
      chk("we_rv2", read_valid, 1);
      chk("we_level2", level, 0);
      rd_en = 1'b0;

      // write+read on full
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; write_data = 16'(16'h0100 + i);
         step();
      end
      chk("f2_full", full, 1);
      rd_en = 1'b1; write_data = 16'h1234;
      step();
      chk("wf_data", read_value, 16'h0100);
      chk("wf_rv", read_valid, 1);
      chk("wf_level", level, 16);
      chk("wf_ovf", overflow, 0);
      wr_en = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("wf_order", read_value, (i == 16) ? 16'h1234 : 16'(16'h0100 + i));
      end
      rd_en = 1'b0;
      step();
      chk("wf_empty", empty, 1);

      // alternating stream, pointers wrap several times
      for (int i = 0; i < 40; i++) begin
         wr_en = 1'b1; rd_en = 1'b0; write_data = 16'(16'h2000 + i);
         step();
         wr_en = 1'b0; rd_en = 1'b1;
         step();
         chk("str_data", read_value, 16'h2000 + i);
         chk("str_rv", read_valid, 1);
         chk("str_level", level, 0);
      end
      rd_en = 1'b0;
      step();
      chk("str_ovf", overflow, 0);
      chk("str_unf", underflow, 0);

      // reset at level 7, with a read competing
      for (int i = 0; i < 7; i++) begin
         wr_en = 1'b1; write_data = 16'(16'h3000 + i);
         step();
      end
      wr_en = 1'b0;
      chk("pre_rst_level", level, 7);
      reset = 1'b1; rd_en = 1'b1;
      step();
      chk("mr_level", level, 0);
      chk("mr_empty", empty, 1);
      chk("mr_rv", read_valid, 0);
      reset = 1'b0;
      step();
      chk("mr_read_rej", read_valid, 0);
      chk("mr_unf", underflow, 1);
      rd_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_fifo_sync.md
SAMPLE_FIFO_SYNC -- requirements
Module: sample_fifo_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning storage entries; power of two, minimum 4.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold (level >= AF_LEVEL).
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold (level <= AE_LEVEL).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock, with all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1, meaning write request.
REQ-008 The block SHALL have port write_data, input, DATA_W, meaning sample to store.
REQ-009 The block SHALL have port rd_en, input, 1, meaning read request.
REQ-010 The block SHALL have port read_value, output, DATA_W, meaning registered read data.
REQ-011 The block SHALL have port read_valid, output, 1, meaning read_value updated this cycle.
REQ-012 The block SHALL have ports full and empty, output, 1 each, meaning occupancy flags.
REQ-013 The block SHALL have ports almost_full and almost_empty, output, 1 each, meaning threshold flags.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1, meaning current entry count.
REQ-015 The block SHALL have ports overflow and underflow, output, 1 each, meaning sticky error flags.
REQ-016 The block SHALL have port clear_err, input, 1, meaning synchronous clear of overflow/underflow.

Function
REQ-017 The block SHALL accept a write when wr_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-018 The block SHALL accept a read when rd_en=1 and empty=0.
REQ-019 An accepted write SHALL store write_data at wr_ptr and advance wr_ptr by 1, wrapping from DEPTH-1 to 0.
REQ-020 An accepted read SHALL load read_value from rd_ptr at the next edge, assert read_valid for that one cycle, and advance rd_ptr with wrap, giving 1-cycle read latency.
REQ-021 read_value SHALL hold its last value when no read is accepted.
REQ-022 level SHALL update each cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 full SHALL equal (level==DEPTH), empty SHALL equal (level==0), and almost_full/almost_empty SHALL follow the thresholds; all four SHALL be derived from registered level with no extra latency.
REQ-024 Simultaneous write and read when full SHALL both be accepted, with level staying at DEPTH.
REQ-025 Simultaneous write and read when empty SHALL accept only the write and reject the read, with level going to 1 and underflow set; there SHALL be no fall-through.
REQ-026 A rejected write (full, no accepted read) SHALL leave memory and pointers unchanged and set overflow.
REQ-027 A rejected read (empty) SHALL leave read_value unchanged, keep read_valid=0, and set underflow.
REQ-028 overflow/underflow SHALL stay set until clear_err=1 or reset; when clear_err and a new error occur in the same cycle, the flag SHALL remain set.
REQ-029 Data order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL clear wr_ptr, rd_ptr and level to 0 and clear read_value, read_valid, overflow and underflow to 0.
REQ-031 After reset, the block SHALL show empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-032 Reset SHALL override wr_en, rd_en and clear_err in the same cycle, and memory contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries, so that a read in the first cycle after reset is rejected.

Verification
REQ-034 Reset then 16 writes of 0x0001..0x0010 SHALL give full=1, level=16 and almost_full asserted from level 14.
REQ-035 A 17th write of 0xBEEF while full SHALL set overflow=1 with level=16, and 16 subsequent reads SHALL return 0x0001..0x0010 in order.
REQ-036 A read on an empty FIFO SHALL set underflow=1 with read_valid=0, and clear_err=1 for one cycle SHALL return underflow to 0.
REQ-037 With full=1, wr_en=rd_en=1 writing 0x1234 SHALL output the oldest entry and keep level=16, and the entry 0x1234 SHALL emerge last.
REQ-038 Streaming 40 samples with alternating write/read SHALL produce wrapped pointers and in-order output with no flags set.
REQ-039 Asserting reset at level=7 SHALL give level=0, empty=1 and read_valid=0 on the next cycle.
